// File: rtl/inst_decode_stage.sv
// Instruction decode stage: decodes RV32/64 base formats at the input and
// queues the decoded fields in a small circular FIFO toward the consumer.
module inst_decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst_in,
   input  logic [XLEN-1:0] pc_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal,
   output logic [XLEN-1:0] pc_out
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic            illegal;
      logic [XLEN-1:0] pc;
   } entry_t;

   entry_t          dec;
   entry_t          head;
   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;

   always_comb begin
      dec         = '0;
      dec.opcode  = inst_in[6:0];
      dec.pc      = pc_in;
      dec.fmt     = FMT_ILL;
      dec.illegal = 1'b1;
      unique case (inst_in[6:0])
         7'b0000011, 7'b0010011, 7'b1100111: begin
            dec.fmt     = FMT_I;
            dec.illegal = 1'b0;
            dec.rd      = inst_in[11:7];
            dec.funct3  = inst_in[14:12];
            dec.rs1     = inst_in[19:15];
            dec.imm     = {{(XLEN-11){inst_in[31]}}, inst_in[30:20]};
         end
         7'b0100011: begin
            dec.fmt     = FMT_S;
            dec.illegal = 1'b0;
            dec.funct3  = inst_in[14:12];
            dec.rs1     = inst_in[19:15];
            dec.rs2     = inst_in[24:20];
            dec.imm     = {{(XLEN-11){inst_in[31]}}, inst_in[30:25], inst_in[11:7]};
         end
         7'b0110011: begin
            dec.fmt     = FMT_R;
            dec.illegal = 1'b0;
            dec.rd      = inst_in[11:7];
            dec.funct3  = inst_in[14:12];
            dec.rs1     = inst_in[19:15];
            dec.rs2     = inst_in[24:20];
            dec.funct7  = inst_in[31:25];
         end
         7'b1100011: begin
            dec.fmt     = FMT_B;
            dec.illegal = 1'b0;
            dec.funct3  = inst_in[14:12];
            dec.rs1     = inst_in[19:15];
            dec.rs2     = inst_in[24:20];
            dec.imm     = {{(XLEN-12){inst_in[31]}}, inst_in[7], inst_in[30:25],
                           inst_in[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec.fmt     = FMT_U;
            dec.illegal = 1'b0;
            dec.rd      = inst_in[11:7];
            dec.imm     = {{(XLEN-31){inst_in[31]}}, inst_in[30:12], 12'b0};
         end
         7'b1101111: begin
            dec.fmt     = FMT_J;
            dec.illegal = 1'b0;
            dec.rd      = inst_in[11:7];
            dec.imm     = {{(XLEN-20){inst_in[31]}}, inst_in[19:12], inst_in[20],
                           inst_in[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   // in_ready depends only on registered count, so no out_ready->in_ready path
   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= dec;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   assign head    = out_valid ? mem[rd_ptr] : '0;
   assign opcode  = head.opcode;
   assign rd      = head.rd;
   assign rs1     = head.rs1;
   assign rs2     = head.rs2;
   assign funct3  = head.funct3;
   assign funct7  = head.funct7;
   assign imm     = head.imm;
   assign fmt     = head.fmt;
   assign illegal = head.illegal;
   assign pc_out  = head.pc;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage (XLEN=32, DEPTH=2): decode formats,
// backpressure ordering, flush and reset behaviour.
module tb_inst_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [31:0] inst_in, pc_in, imm, pc_out;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3, fmt;

   int total = 0;
   int bad   = 0;

   inst_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in), .pc_in(pc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm), .fmt(fmt),
      .illegal(illegal), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      in_valid = v;
      inst_in  = inst;
      pc_in    = pc;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_fields"}, {opcode, rd, rs1, rs2, funct3, funct7, fmt, illegal}, 64'd0);
      chk({tag, "_imm"}, 64'(imm), 64'd0);
      chk({tag, "_pc"}, 64'(pc_out), 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drv(1'b0, 32'h0, 32'h0);
      step(); step();
      rst = 1'b0;
      chk_empty("reset");

      // Chain of pushes with out_ready=1: each cycle pops the previous entry.
      out_ready = 1'b1;
      drv(1'b1, 32'hFFF10093, 32'h100);   // addi x1,x2,-1
      step();
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi_fmt", 64'(fmt), 64'd1);
      chk("addi_regs", {rd, rs1, rs2}, {5'd1, 5'd2, 5'd0});
      chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
      chk("addi_pc", 64'(pc_out), 64'h100);

      drv(1'b1, 32'h00112623, 32'h104);   // sw x1,12(x2)
      step();
      chk("sw_fmt", 64'(fmt), 64'd2);
      chk("sw_regs", {rd, rs1, rs2, funct3}, {5'd0, 5'd2, 5'd1, 3'd2});
      chk("sw_imm", 64'(imm), 64'd12);
      chk("sw_pc", 64'(pc_out), 64'h104);

      drv(1'b1, 32'hFE000EE3, 32'h108);   // beq x0,x0,-4
      step();
      chk("beq_fmt", 64'(fmt), 64'd3);
      chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
      chk("beq_rd_f7", {rd, funct7}, 64'd0);

      drv(1'b1, 32'h123452B7, 32'h10C);   // lui x5,0x12345
      step();
      chk("lui_fmt", 64'(fmt), 64'd4);
      chk("lui_rd", 64'(rd), 64'd5);
      chk("lui_imm", 64'(imm), 64'h12345000);
      chk("lui_rs", {rs1, rs2, funct3}, 64'd0);

      drv(1'b1, 32'h402081B3, 32'h110);   // sub x3,x1,x2
      step();
      chk("sub_fmt", 64'(fmt), 64'd0);
      chk("sub_regs", {rd, rs1, rs2, funct3, funct7}, {5'd3, 5'd1, 5'd2, 3'd0, 7'h20});
      chk("sub_imm", 64'(imm), 64'd0);

      drv(1'b1, 32'h008000EF, 32'h114);   // jal x1,8
      step();
      chk("jal_fmt", 64'(fmt), 64'd5);
      chk("jal_rd", 64'(rd), 64'd1);
      chk("jal_imm", 64'(imm), 64'd8);

      drv(1'b1, 32'h00000000, 32'h118);   // unsupported opcode
      step();
      chk("ill_valid", 64'(out_valid), 64'd1);
      chk("ill_flag", 64'(illegal), 64'd1);
      chk("ill_fmt", 64'(fmt), 64'd7);
      chk("ill_fields", {opcode, rd, rs1, rs2, funct3, funct7, imm}, 64'd0);
      chk("ill_pc", 64'(pc_out), 64'h118);

      drv(1'b0, 32'h0, 32'h0);
      step();
      chk_empty("drain");

      // Backpressure with DEPTH=2: third push must wait for a pop.
      out_ready = 1'b0;
      drv(1'b1, 32'hFFF10093, 32'h200);
      step();
      chk("bp_ready1", 64'(in_ready), 64'd1);
      drv(1'b1, 32'h00112623, 32'h204);
      step();
      chk("bp_full", 64'(in_ready), 64'd0);
      drv(1'b1, 32'h123452B7, 32'h208);
      step();
      chk("bp_stall_ready", 64'(in_ready), 64'd0);
      chk("bp_head0", 64'(pc_out), 64'h200);
      out_ready = 1'b1;
      step();
      chk("bp_head1", 64'(pc_out), 64'h204);
      chk("bp_head1_fmt", 64'(fmt), 64'd2);
      chk("bp_ready2", 64'(in_ready), 64'd1);
      step();
      chk("bp_head2", 64'(pc_out), 64'h208);
      chk("bp_head2_fmt", 64'(fmt), 64'd4);
      drv(1'b0, 32'h0, 32'h0);
      step();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // Flush with two buffered entries and a pending input.
      out_ready = 1'b0;
      drv(1'b1, 32'hFFF10093, 32'h300);
      step();
      drv(1'b1, 32'h00112623, 32'h304);
      step();
      chk("fl_full", 64'(in_ready), 64'd0);
      flush = 1'b1;
      drv(1'b1, 32'h123452B7, 32'h308);
      step();
      flush = 1'b0;
      drv(1'b0, 32'h0, 32'h0);
      chk_empty("flush2");
      out_ready = 1'b1;
      drv(1'b1, 32'h008000EF, 32'h400);
      step();
      drv(1'b0, 32'h0, 32'h0);
      chk("fl_next_pc", 64'(pc_out), 64'h400);
      chk("fl_next_fmt", 64'(fmt), 64'd5);
      step();
      chk("fl_no_ghost", 64'(out_valid), 64'd0);

      // Flush with one entry and an acceptable push: the push is dropped too.
      out_ready = 1'b0;
      drv(1'b1, 32'hFFF10093, 32'h500);
      step();
      flush = 1'b1; out_ready = 1'b1;
      drv(1'b1, 32'h00112623, 32'h504);
      step();
      flush = 1'b0;
      drv(1'b0, 32'h0, 32'h0);
      chk_empty("flush1");
      step();
      chk("fl1_still_empty", 64'(out_valid), 64'd0);

      // Reset wins over concurrent flush and push.
      out_ready = 1'b0;
      drv(1'b1, 32'h123452B7, 32'h600);
      step();
      chk("rs_count1", 64'(pc_out), 64'h600);
      rst = 1'b1; flush = 1'b1;
      drv(1'b1, 32'hFFF10093, 32'h604);
      step();
      rst = 1'b0; flush = 1'b0;
      drv(1'b0, 32'h0, 32'h0);
      chk_empty("midreset");
      step();
      chk("rs_stays_empty", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
